// File: rtl/online_div_pkg.sv
// rtl/online_div_pkg.sv - signed-digit encodings and converter state shared by the online divider blocks
package online_div_pkg;

   localparam logic [1:0] SD_POS  = 2'b10;
   localparam logic [1:0] SD_NEG  = 2'b01;
   localparam logic [1:0] SD_ZERO = 2'b00;
   localparam logic [1:0] SD_ILL  = 2'b11;

   typedef enum logic {
      ACCUM = 1'b0,
      HOLD  = 1'b1
   } conv_state_e;

endpackage

// File: rtl/online_q_converter_if.sv
// rtl/online_q_converter_if.sv - digit input stream and quotient output handshake of the converter
interface online_q_converter_if #(
   parameter int NUM_DIGITS = 64
);
   logic [1:0]          q_value;
   logic                data_in_vld;
   logic                data_in_rdy;
   logic [NUM_DIGITS:0] q_bin;
   logic                q_bin_vld;
   logic                q_bin_rdy;

   modport master (
      output q_value, data_in_vld, q_bin_rdy,
      input  data_in_rdy, q_bin, q_bin_vld
   );

   modport slave (
      input  q_value, data_in_vld, q_bin_rdy,
      output data_in_rdy, q_bin, q_bin_vld
   );
endinterface

// File: rtl/otf_append.sv
// rtl/otf_append.sv - one on-the-fly conversion step: appends a signed digit to the Q/QM pair
module otf_append
   import online_div_pkg::*;
#(
   parameter int W = 65
) (
   input  logic [W-1:0] q,
   input  logic [W-1:0] qm,
   input  logic [1:0]   digit,
   output logic [W-1:0] q_next,
   output logic [W-1:0] qm_next
);

   // QM always holds Q - 1 ulp, so a negative digit borrows from QM instead of propagating a carry
   always_comb begin
      q_next  = {q[W-2:0], 1'b0};
      qm_next = {qm[W-2:0], 1'b1};
      case (digit)
         SD_POS: begin
            q_next  = {q[W-2:0], 1'b1};
            qm_next = {q[W-2:0], 1'b0};
         end
         SD_NEG: begin
            q_next  = {qm[W-2:0], 1'b1};
            qm_next = {qm[W-2:0], 1'b0};
         end
         default: begin
            q_next  = {q[W-2:0], 1'b0};
            qm_next = {qm[W-2:0], 1'b1};
         end
      endcase
   end

endmodule

// File: rtl/online_q_converter.sv
// rtl/online_q_converter.sv - collects NUM_DIGITS quotient digits into a two's-complement word; ONLINE_Q_CONV_ERR_EN adds err_illegal_digit
module online_q_converter
   import online_div_pkg::*;
#(
   parameter int NUM_DIGITS = 64,
   parameter int CNT_WIDTH  = 9
) (
   input  logic                 clk,
   input  logic                 asyn_reset_n,
   online_q_converter_if.slave  dig_if,
   input  logic                 conv_clear,
`ifdef ONLINE_Q_CONV_ERR_EN
   output logic                 err_illegal_digit,
`endif
   output logic [CNT_WIDTH-1:0] digit_cnt
);

   localparam int                   W        = NUM_DIGITS + 1;
   localparam logic [CNT_WIDTH-1:0] LAST_CNT = CNT_WIDTH'(NUM_DIGITS - 1);

   conv_state_e          state_q, state_d;
   logic [W-1:0]         q_q, q_d;
   logic [W-1:0]         qm_q, qm_d;
   logic [CNT_WIDTH-1:0] cnt_q, cnt_d;
   logic [W-1:0]         q_app, qm_app;
   logic                 dig_acc, bin_acc;

   otf_append #(.W(W)) u_otf_append (
      .q       (q_q),
      .qm      (qm_q),
      .digit   (dig_if.q_value),
      .q_next  (q_app),
      .qm_next (qm_app)
   );

   assign dig_acc = dig_if.data_in_vld & (state_q == ACCUM);
   assign bin_acc = dig_if.q_bin_rdy & (state_q == HOLD);

   always_comb begin
      state_d = state_q;
      q_d     = q_q;
      qm_d    = qm_q;
      cnt_d   = cnt_q;
      if (conv_clear) begin
         state_d = ACCUM;
         q_d     = '0;
         qm_d    = '1;
         cnt_d   = '0;
      end else begin
         unique case (state_q)
            ACCUM: begin
               if (dig_acc) begin
                  q_d   = q_app;
                  qm_d  = qm_app;
                  cnt_d = cnt_q + 1'b1;
                  if (cnt_q == LAST_CNT) begin
                     state_d = HOLD;
                  end
               end
            end
            HOLD: begin
               if (bin_acc) begin
                  state_d = ACCUM;
                  q_d     = '0;
                  qm_d    = '1;
                  cnt_d   = '0;
               end
            end
         endcase
      end
   end

   always_ff @(posedge clk or negedge asyn_reset_n) begin
      if (!asyn_reset_n) begin
         state_q <= ACCUM;
         q_q     <= '0;
         qm_q    <= '1;
         cnt_q   <= '0;
      end else begin
         state_q <= state_d;
         q_q     <= q_d;
         qm_q    <= qm_d;
         cnt_q   <= cnt_d;
      end
   end

   // Ready is gated by reset directly so it is low for the whole reset window
   assign dig_if.data_in_rdy = (state_q == ACCUM) & asyn_reset_n;
   assign dig_if.q_bin_vld   = (state_q == HOLD);
   assign dig_if.q_bin       = (state_q == HOLD) ? q_q : '0;
   assign digit_cnt          = cnt_q;

`ifdef ONLINE_Q_CONV_ERR_EN
   logic err_q, err_d;

   always_comb begin
      err_d = err_q;
      if (conv_clear || bin_acc) begin
         err_d = 1'b0;
      end else if (dig_acc && (dig_if.q_value == SD_ILL)) begin
         err_d = 1'b1;
      end
   end

   always_ff @(posedge clk or negedge asyn_reset_n) begin
      if (!asyn_reset_n) begin
         err_q <= 1'b0;
      end else begin
         err_q <= err_d;
      end
   end

   assign err_illegal_digit = err_q;
`endif

endmodule

// File: tb/tb_online_q_converter.sv
// tb/tb_online_q_converter.sv - scoreboard bench for online_q_converter with NUM_DIGITS = 8
module tb_online_q_converter;

   localparam int ND = 8;
   localparam int CW = 4;

   localparam logic [1:0] P = 2'b10;
   localparam logic [1:0] N = 2'b01;
   localparam logic [1:0] Z = 2'b00;
   localparam logic [1:0] I = 2'b11;

   logic          clk = 1'b0;
   logic          asyn_reset_n;
   logic          conv_clear;
   logic [CW-1:0] digit_cnt;
`ifdef ONLINE_Q_CONV_ERR_EN
   logic          err_illegal_digit;
`endif

   int checks   = 0;
   int failures = 0;
   logic [ND:0] exp_q[$];

   always #5 clk = ~clk;

   online_q_converter_if #(.NUM_DIGITS(ND)) dif ();

   online_q_converter #(.NUM_DIGITS(ND), .CNT_WIDTH(CW)) dut (
      .clk               (clk),
      .asyn_reset_n      (asyn_reset_n),
      .dig_if            (dif),
      .conv_clear        (conv_clear),
`ifdef ONLINE_Q_CONV_ERR_EN
      .err_illegal_digit (err_illegal_digit),
`endif
      .digit_cnt         (digit_cnt)
   );

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=%h expected=%h", name, act, exp);
      end
   endtask

   // Monitor: every quotient handshake is compared against the oldest expected value
   always @(negedge clk) begin
      if (asyn_reset_n && dif.q_bin_vld && dif.q_bin_rdy) begin
         if (exp_q.size() == 0) begin
            checks++;
            failures++;
            $display("FAIL unexpected_q_bin actual=%h expected=none", dif.q_bin);
         end else begin
            check("q_bin", 32'(dif.q_bin), 32'(exp_q.pop_front()));
         end
      end
   end

   task automatic send_digit(input logic [1:0] d);
      int n = 0;
      dif.q_value     = d;
      dif.data_in_vld = 1'b1;
      while (!dif.data_in_rdy && n < 50) begin
         @(posedge clk);
         #1;
         n++;
      end
      check("data_in_rdy_wait", 32'(dif.data_in_rdy), 32'd1);
      @(posedge clk);
      #1;
      dif.data_in_vld = 1'b0;
      dif.q_value     = 2'b00;
   endtask

   task automatic send_seq(input logic [2*ND-1:0] ds);
      for (int i = 0; i < ND; i++) begin
         if (i == ND - 1) check("no_early_vld", 32'(dif.q_bin_vld), 32'd0);
         send_digit(ds[2*ND-1-2*i -: 2]);
      end
   endtask

   task automatic accept();
      dif.q_bin_rdy = 1'b1;
      @(posedge clk);
      #1;
      dif.q_bin_rdy = 1'b0;
      check("vld_after_accept", 32'(dif.q_bin_vld), 32'd0);
      check("cnt_after_accept", 32'(digit_cnt), 32'd0);
      check("rdy_after_accept", 32'(dif.data_in_rdy), 32'd1);
   endtask

   task automatic run_div(input logic [2*ND-1:0] ds, input logic [ND:0] exp);
      exp_q.push_back(exp);
      send_seq(ds);
      check("latency_vld", 32'(dif.q_bin_vld), 32'd1);
      check("cnt_full", 32'(digit_cnt), 32'(ND));
      accept();
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog actual=timeout expected=finish");
      $fatal(1);
   end

   initial begin
      asyn_reset_n    = 1'b0;
      conv_clear      = 1'b0;
      dif.q_value     = 2'b00;
      dif.data_in_vld = 1'b0;
      dif.q_bin_rdy   = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      check("rst_rdy", 32'(dif.data_in_rdy), 32'd0);
      check("rst_vld", 32'(dif.q_bin_vld), 32'd0);
      check("rst_qbin", 32'(dif.q_bin), 32'd0);
      check("rst_cnt", 32'(digit_cnt), 32'd0);
      asyn_reset_n = 1'b1;
      @(posedge clk);
      #1;
      check("post_rst_rdy", 32'(dif.data_in_rdy), 32'd1);

      run_div({P, Z, Z, Z, Z, Z, Z, Z}, 9'h080);
      run_div({N, Z, Z, Z, Z, Z, Z, Z}, 9'h180);
      run_div({P, N, Z, Z, Z, Z, Z, Z}, 9'h040);
      run_div({N, N, N, N, N, N, N, N}, 9'h101);
      run_div({P, P, P, P, P, P, P, P}, 9'h0FF);
      run_div({Z, P, Z, Z, Z, Z, Z, N}, 9'h03F);
`ifndef ONLINE_Q_CONV_ERR_EN
      run_div({P, Z, I, Z, Z, Z, Z, Z}, 9'h080);
`endif

      // Back-pressure in HOLD while offering digits that must be ignored
      exp_q.push_back(9'h0C0);
      send_seq({P, P, Z, Z, Z, Z, Z, Z});
      dif.data_in_vld = 1'b1;
      dif.q_value     = P;
      for (int c = 0; c < 5; c++) begin
         check("hold_qbin", 32'(dif.q_bin), 32'h0C0);
         check("hold_rdy", 32'(dif.data_in_rdy), 32'd0);
         check("hold_cnt", 32'(digit_cnt), 32'(ND));
         @(posedge clk);
         #1;
      end
      dif.data_in_vld = 1'b0;
      dif.q_value     = Z;
      accept();

      // Abort after four digits, with a digit presented alongside the clear
      send_digit(N);
      send_digit(N);
      send_digit(P);
      send_digit(N);
      check("cnt_before_clear", 32'(digit_cnt), 32'd4);
      conv_clear      = 1'b1;
      dif.data_in_vld = 1'b1;
      dif.q_value     = N;
      @(posedge clk);
      #1;
      conv_clear      = 1'b0;
      dif.data_in_vld = 1'b0;
      dif.q_value     = Z;
      check("cnt_after_clear", 32'(digit_cnt), 32'd0);
      run_div({P, Z, Z, Z, Z, Z, Z, Z}, 9'h080);

      // Clear while holding a result drops it
      send_seq({P, P, P, Z, Z, Z, Z, Z});
      check("vld_before_hold_clear", 32'(dif.q_bin_vld), 32'd1);
      conv_clear = 1'b1;
      @(posedge clk);
      #1;
      conv_clear = 1'b0;
      check("vld_after_hold_clear", 32'(dif.q_bin_vld), 32'd0);
      check("cnt_after_hold_clear", 32'(digit_cnt), 32'd0);
      run_div({N, P, Z, Z, Z, Z, Z, Z}, 9'h1C0);

`ifdef ONLINE_Q_CONV_ERR_EN
      exp_q.push_back(9'h0C0);
      send_digit(P);
      send_digit(P);
      check("err_before_ill", 32'(err_illegal_digit), 32'd0);
      send_digit(I);
      check("err_after_ill", 32'(err_illegal_digit), 32'd1);
      for (int i = 0; i < 5; i++) send_digit(Z);
      check("err_in_hold", 32'(err_illegal_digit), 32'd1);
      check("err_div_vld", 32'(dif.q_bin_vld), 32'd1);
      accept();
      check("err_after_accept", 32'(err_illegal_digit), 32'd0);
`endif

      // Reset while holding a result: outputs drop without waiting for a clock
      send_seq({P, Z, P, Z, Z, Z, Z, Z});
      check("vld_before_reset", 32'(dif.q_bin_vld), 32'd1);
      asyn_reset_n = 1'b0;
      #1;
      check("midrst_qbin", 32'(dif.q_bin), 32'd0);
      check("midrst_vld", 32'(dif.q_bin_vld), 32'd0);
      check("midrst_rdy", 32'(dif.data_in_rdy), 32'd0);
      check("midrst_cnt", 32'(digit_cnt), 32'd0);
      @(negedge clk);
      asyn_reset_n = 1'b1;
      @(posedge clk);
      #1;
      run_div({P, Z, Z, Z, Z, Z, Z, P}, 9'h081);

      repeat (3) @(posedge clk);
      #1;
      check("scoreboard_empty", 32'(exp_q.size()), 32'd0);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
